// File: rtl/tt_um_adder8_seq_pkg.sv
// rtl/tt_um_adder8_seq_pkg.sv - shared encodings for the 8-bit operand sequencer/adder tile
package tt_um_adder8_seq_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    ST_WAIT_A = 2'b00,
    ST_WAIT_B = 2'b01,
    ST_ACCUM  = 2'b10
  } state_t;

  localparam int STB_BIT   = 0;
  localparam int MODE_BIT  = 1;
  localparam int CLR_BIT   = 2;
  localparam int CARRY_BIT = 7;
  localparam int VALID_BIT = 6;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/tt_um_adder8_seq_if.sv
// rtl/tt_um_adder8_seq_if.sv - tile pin bundle shared by the adder tile and its driver
interface tt_um_adder8_seq_if;
  import tt_um_adder8_seq_pkg::*;

  logic             ena;
  logic [WIDTH-1:0] ui_in;
  logic [7:0]       uio_in;
  logic [WIDTH-1:0] uo_out;
  logic [7:0]       uio_out;
  logic [7:0]       uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/tt_um_adder8_seq_sync.sv
// rtl/tt_um_adder8_seq_sync.sv - multi-flop synchroniser with one-clock rising-edge pulse
module tt_sync_rise #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic pulse
);

  logic [STAGES-1:0] chain;
  logic              delay;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      delay <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      delay <= chain[STAGES-1];
    end
  end

  assign sync  = chain[STAGES-1];
  assign pulse = sync & ~delay;

endmodule

// File: rtl/tt_um_adder8_seq.sv
// rtl/tt_um_adder8_seq.sv - strobed operand sequencer with registered pair-add / accumulate
module tt_um_adder8_seq
  import tt_um_adder8_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  tt_um_adder8_seq_if.slave   bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, a_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] result, result_nxt;
  logic             carry, carry_nxt;
  logic             valid, valid_nxt;

  logic             stb_pulse;
  logic             clr_level;
  logic             stb_level_unused;
  logic             clr_pulse_unused;
  logic             unused_pins;

  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum;

  tt_sync_rise #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.uio_in[STB_BIT]),
    .sync  (stb_level_unused),
    .pulse (stb_pulse)
  );

  tt_sync_rise #(.STAGES(SYNC_STAGES)) u_clr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.uio_in[CLR_BIT]),
    .sync  (clr_level),
    .pulse (clr_pulse_unused)
  );

  assign unused_pins = &{1'b0, bus.ena, bus.uio_in[7:3]};

  // One adder serves both modes: the pending A only matters while finishing a pair.
  assign operand = (state == ST_WAIT_B) ? a_reg : acc;
  assign sum     = {1'b0, operand} + {1'b0, bus.ui_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_WAIT_A;
      a_reg  <= '0;
      acc    <= '0;
      result <= '0;
      carry  <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_reg  <= a_nxt;
      acc    <= acc_nxt;
      result <= result_nxt;
      carry  <= carry_nxt;
      valid  <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    a_nxt      = a_reg;
    acc_nxt    = acc;
    result_nxt = result;
    carry_nxt  = carry;
    valid_nxt  = valid;
    if (clr_level) begin
      state_nxt  = ST_WAIT_A;
      acc_nxt    = '0;
      result_nxt = '0;
      carry_nxt  = 1'b0;
      valid_nxt  = 1'b0;
    end else if (stb_pulse) begin
      case (state)
        ST_WAIT_B: begin
          result_nxt = sum[WIDTH-1:0];
          carry_nxt  = sum[WIDTH];
          valid_nxt  = 1'b1;
          state_nxt  = ST_WAIT_A;
        end
        ST_WAIT_A, ST_ACCUM: begin
          if (bus.uio_in[MODE_BIT]) begin
            acc_nxt    = sum[WIDTH-1:0];
            result_nxt = sum[WIDTH-1:0];
            carry_nxt  = sum[WIDTH];
            valid_nxt  = 1'b1;
            state_nxt  = ST_ACCUM;
          end else begin
            a_nxt     = bus.ui_in;
            valid_nxt = 1'b0;
            state_nxt = ST_WAIT_B;
          end
        end
        default: state_nxt = ST_WAIT_A;
      endcase
    end
  end

  assign bus.uo_out  = result;
  assign bus.uio_out = {carry, valid, state, 4'b0000};
  assign bus.uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_adder8_seq.sv
// tb/tb_tt_um_adder8_seq.sv - directed self-checking bench for the adder tile
module tb_tt_um_adder8_seq;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  bit   check_en = 0;

  // Reference model in plain arithmetic: phase 0=wait A, 1=wait B, 2=accumulate
  int   m_ph, m_a, m_acc, m_res, m_carry, m_valid;

  tt_um_adder8_seq_if bus ();

  tt_um_adder8_seq #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_uio();
    logic [1:0] code;
    code = 2'(m_ph);
    return {m_carry[0], m_valid[0], code, 4'b0000};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_a = 0; m_acc = 0; m_res = 0; m_carry = 0; m_valid = 0;
  endtask

  task automatic model_clear();
    m_ph = 0; m_acc = 0; m_res = 0; m_carry = 0; m_valid = 0;
  endtask

  task automatic model_strobe(input int data, input bit mode);
    int sum;
    if (m_ph == 1) begin
      sum = m_a + data;
      m_res = sum % 256; m_carry = (sum > 255) ? 1 : 0; m_valid = 1; m_ph = 0;
    end else if (mode) begin
      sum = m_acc + data;
      m_acc = sum % 256; m_res = m_acc; m_carry = (sum > 255) ? 1 : 0; m_valid = 1; m_ph = 2;
    end else begin
      m_a = data; m_valid = 0; m_ph = 1;
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_uo_out", bus.uo_out, 8'(m_res));
      check("cyc_uio_out", bus.uio_out, model_uio());
      check("cyc_uio_oe", bus.uio_oe, 8'hF0);
    end
  end

  // Outputs change on the 3rd rising edge after the strobe is raised at a falling edge.
  task automatic do_strobe(input logic [7:0] data);
    @(negedge clk); bus.ui_in = data;
    repeat (3) @(negedge clk);
    bus.uio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    model_strobe(int'(data), bus.uio_in[1]);
    @(negedge clk); bus.uio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_clear(input int clks);
    @(negedge clk); bus.uio_in[2] = 1'b1;
    repeat (3) @(posedge clk);
    model_clear();
    repeat (clks - 2) @(negedge clk);
    bus.uio_in[2] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_pins(input string name, input logic [7:0] uo, input logic [7:0] uio);
    @(negedge clk); #1;
    check({name, "_uo"}, bus.uo_out, uo);
    check({name, "_uio"}, bus.uio_out, uio);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_uo", bus.uo_out, 8'h00);
    check("rst_uio", bus.uio_out, 8'h00);
    check("rst_oe", bus.uio_oe, 8'hF0);
    @(negedge clk); rst_n = 1'b1; check_en = 1;

    // Pair add
    bus.uio_in[1] = 1'b0;
    do_strobe(8'h3C);
    do_strobe(8'h05);
    expect_pins("pair", 8'h41, 8'h40);

    // Overflow, then a new A capture drops valid but keeps result/carry
    do_strobe(8'hFF);
    do_strobe(8'h02);
    expect_pins("ovf", 8'h01, 8'hC0);
    do_strobe(8'h10);
    expect_pins("ovf_next_a", 8'h01, 8'h90);

    // Accumulate from clear
    do_clear(3);
    bus.uio_in[1] = 1'b1;
    repeat (2) @(negedge clk);
    do_strobe(8'h80);
    expect_pins("acc1", 8'h80, 8'h60);
    do_strobe(8'h80);
    expect_pins("acc2", 8'h00, 8'hE0);
    do_strobe(8'h10);
    expect_pins("acc3", 8'h10, 8'h60);

    // Clear mid-pair discards A
    bus.uio_in[1] = 1'b0;
    repeat (2) @(negedge clk);
    do_strobe(8'h22);
    do_clear(5);
    expect_pins("clr_mid", 8'h00, 8'h00);
    do_strobe(8'h01);
    do_strobe(8'h02);
    expect_pins("after_clr", 8'h03, 8'h40);

    // Strobe held high 50 clocks: one capture only, later data ignored
    bus.uio_in[1] = 1'b1;
    @(negedge clk); bus.ui_in = 8'h07;
    repeat (3) @(negedge clk);
    bus.uio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    model_strobe(7, 1'b1);
    repeat (5) @(negedge clk);
    bus.ui_in = 8'h99;
    repeat (44) @(negedge clk);
    expect_pins("held", 8'h07, 8'h60);
    bus.uio_in[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Strobe raised together with clear: clear wins, no capture
    @(negedge clk); bus.ui_in = 8'h44;
    repeat (3) @(negedge clk);
    bus.uio_in[0] = 1'b1; bus.uio_in[2] = 1'b1;
    repeat (3) @(posedge clk);
    model_clear();
    repeat (4) @(negedge clk);
    bus.uio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus.uio_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    expect_pins("stb_clr", 8'h00, 8'h00);

    // Async reset mid-pair aborts the pending A
    bus.uio_in[1] = 1'b0;
    repeat (2) @(negedge clk);
    do_strobe(8'h10);
    do_strobe(8'h20);
    do_strobe(8'h55);
    expect_pins("pre_rst", 8'h30, 8'h10);
    @(posedge clk); #3;
    check_en = 0;
    rst_n = 1'b0;
    #1;
    check("arst_uo", bus.uo_out, 8'h00);
    check("arst_uio", bus.uio_out, 8'h00);
    check("arst_oe", bus.uio_oe, 8'hF0);
    @(negedge clk); model_reset();
    @(negedge clk); rst_n = 1'b1; check_en = 1;
    do_strobe(8'h01);
    do_strobe(8'h01);
    expect_pins("post_rst", 8'h02, 8'h40);

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
